// File: rtl/rtc_time_setter.sv
// Manual time-entry front end: debounces the set buttons, edits a BCD HH:MM:SS
// copy of the live time while the manual switch is on, then issues a one-cycle load.
module rtc_time_setter #(
  parameter int DEBOUNCE_TICK_CNT = 49999,
  parameter int SHIFT_DEPTH       = 8,
  parameter int HOLD_TICKS        = 500,
  parameter int REPEAT_TICKS      = 200
) (
  input  logic        clock50MHz,
  input  logic        resetn,
  input  logic        man_switch,
  input  logic [2:0]  push_button,
  input  logic [23:0] cur_time,
  output logic [23:0] set_time,
  output logic        set_load,
  output logic        set_active
);

  localparam int TICK_W   = (DEBOUNCE_TICK_CNT > 0) ? $clog2(DEBOUNCE_TICK_CNT + 1) : 1;
  localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_EDIT,
    S_COMMIT
  } state_t;

  // ---------------------------------------------------------------------------
  // BCD field increment helpers (no carry out of a field)
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] inc_min_sec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] inc_hours(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)           r = 8'h00;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizers and switch edge detection
  // ---------------------------------------------------------------------------
  logic [2:0] r_btn_meta;
  logic [2:0] r_btn_sync;
  logic       r_sw_meta;
  logic       r_sw_sync;
  logic       r_sw_prev;
  logic [1:0] r_sw_valid;
  logic       w_sw_rise;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      r_btn_meta <= 3'b111;
      r_btn_sync <= 3'b111;
      r_sw_meta  <= 1'b0;
      r_sw_sync  <= 1'b0;
      r_sw_prev  <= 1'b1;
      r_sw_valid <= 2'b00;
    end else begin
      r_btn_meta <= push_button;
      r_btn_sync <= r_btn_meta;
      r_sw_meta  <= man_switch;
      r_sw_sync  <= r_sw_meta;
      r_sw_valid <= {r_sw_valid[0], 1'b1};
      // Edge history is held high until the synchronizer has refilled, so a
      // switch left on through reset is not mistaken for a fresh rise.
      r_sw_prev  <= r_sw_valid[1] ? r_sw_sync : 1'b1;
    end
  end

  assign w_sw_rise = r_sw_sync & ~r_sw_prev;

  // ---------------------------------------------------------------------------
  // Debounce sample tick
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TICK_W'(DEBOUNCE_TICK_CNT));

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn)     r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TICK_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Per-button debounce, press edge and hold/auto-repeat
  // ---------------------------------------------------------------------------
  logic [2:0] w_inc;

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic [SHIFT_DEPTH-1:0] r_shift;
    logic                   r_pressed;
    logic                   r_pressed_d;
    logic                   r_repeat;
    logic                   r_inc;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   w_rise;
    logic [HOLD_W-1:0]      w_limit;

    always_ff @(posedge clock50MHz or negedge resetn) begin
      if (!resetn) begin
        r_shift     <= '0;
        r_pressed   <= 1'b0;
        r_pressed_d <= 1'b0;
      end else begin
        if (w_tick) r_shift <= {r_shift[SHIFT_DEPTH-2:0], ~r_btn_sync[g]};
        if (&r_shift)       r_pressed <= 1'b1;
        else if (~|r_shift) r_pressed <= 1'b0;
        r_pressed_d <= r_pressed;
      end
    end

    assign w_rise  = r_pressed & ~r_pressed_d;
    assign w_limit = r_repeat ? HOLD_W'(REPEAT_TICKS - 1) : HOLD_W'(HOLD_TICKS - 1);

    // Counts ticks while held; the first fire ends the initial hold period
    // and switches the terminal count to the repeat interval.
    always_ff @(posedge clock50MHz or negedge resetn) begin
      if (!resetn) begin
        r_hold_cnt <= '0;
        r_repeat   <= 1'b0;
        r_inc      <= 1'b0;
      end else begin
        r_inc <= 1'b0;
        if (w_rise) begin
          r_inc      <= 1'b1;
          r_hold_cnt <= '0;
          r_repeat   <= 1'b0;
        end else if (!r_pressed) begin
          r_hold_cnt <= '0;
          r_repeat   <= 1'b0;
        end else if (w_tick) begin
          if (r_hold_cnt == w_limit) begin
            r_inc      <= 1'b1;
            r_hold_cnt <= '0;
            r_repeat   <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
      end
    end

    assign w_inc[g] = r_inc;
  end

  // ---------------------------------------------------------------------------
  // Set-mode FSM
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_next_state;

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: the default assignment at the top of a combinational block keeps
  // every path assigned, so no latch is inferred for unlisted cases.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_sw_rise)  w_next_state = S_CAPTURE;
      S_CAPTURE:                 w_next_state = S_EDIT;
      S_EDIT:    if (!r_sw_sync) w_next_state = S_COMMIT;
      S_COMMIT:                  w_next_state = S_IDLE;
      default:                   w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Edit register
  // ---------------------------------------------------------------------------
  logic [23:0] r_edit;
  logic [23:0] w_edit_next;

  // Increments landing on the EDIT exit cycle are dropped so the committed
  // value is exactly what was shown on entry to COMMIT.
  always_comb begin
    w_edit_next = r_edit;
    if (r_state == S_CAPTURE) begin
      w_edit_next = cur_time;
    end else if (r_state == S_EDIT && w_next_state == S_EDIT) begin
      if (w_inc[2]) w_edit_next[23:16] = inc_hours(r_edit[23:16]);
      if (w_inc[1]) w_edit_next[15:8]  = inc_min_sec(r_edit[15:8]);
      if (w_inc[0]) w_edit_next[7:0]   = inc_min_sec(r_edit[7:0]);
    end
  end

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) r_edit <= '0;
    else         r_edit <= w_edit_next;
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic r_set_load;
  logic r_set_active;

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      r_set_load   <= 1'b0;
      r_set_active <= 1'b0;
    end else begin
      r_set_load   <= (w_next_state == S_COMMIT);
      r_set_active <= (w_next_state == S_EDIT);
    end
  end

  assign set_time   = r_edit;
  assign set_load   = r_set_load;
  assign set_active = r_set_active;

endmodule

// File: tb/tb_rtc_time_setter.sv
// Directed bench for rtc_time_setter: vector table of edit sessions plus
// hand-written sequences for wrap, bounce, auto-repeat, simultaneity and reset.
module tb_rtc_time_setter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        man_switch;
  logic [2:0]  push_button;
  logic [23:0] cur_time;
  logic [23:0] set_time;
  logic        set_load;
  logic        set_active;

  rtc_time_setter #(
    .DEBOUNCE_TICK_CNT(3),
    .SHIFT_DEPTH      (4),
    .HOLD_TICKS       (8),
    .REPEAT_TICKS     (4)
  ) dut (
    .clock50MHz (clk),
    .resetn     (resetn),
    .man_switch (man_switch),
    .push_button(push_button),
    .cur_time   (cur_time),
    .set_time   (set_time),
    .set_load   (set_load),
    .set_active (set_active)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_loads  = 0;
  int          exp_loads = 0;
  logic [23:0] last_load = '0;

  int          nchg;
  logic [23:0] chg_val [8];
  int          chg_at  [8];

  typedef struct {
    logic [23:0] cur;
    logic [2:0]  mask;
    logic [23:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [8];

  always @(negedge clk) begin
    if (set_load) begin
      n_loads   = n_loads + 1;
      last_load = set_time;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: long enough to debounce, shorter than the hold period.
  task automatic press(input logic [2:0] mask, input int low_clks);
    push_button = ~mask;
    wait_clks(low_clks);
    push_button = 3'b111;
    wait_clks(60);
  endtask

  // Optional bounce phase, then a steady low, then release; logs set_time changes.
  task automatic drive_and_watch(input logic [2:0] mask, input int bounce_clks,
                                 input int low_clks, input int tail_clks);
    logic [23:0] prev;
    int          total;
    total = bounce_clks + low_clks + tail_clks;
    nchg  = 0;
    for (int i = 0; i < 8; i++) begin
      chg_val[i] = '0;
      chg_at[i]  = 0;
    end
    prev = set_time;
    for (int c = 0; c < total; c++) begin
      if (c < bounce_clks)
        push_button = (((c / 5) % 2) == 0) ? ~mask : 3'b111;
      else if (c < bounce_clks + low_clks)
        push_button = ~mask;
      else
        push_button = 3'b111;
      @(negedge clk);
      if (set_time !== prev) begin
        if (nchg < 8) begin
          chg_val[nchg] = set_time;
          chg_at[nchg]  = c;
        end
        nchg++;
        prev = set_time;
      end
    end
  endtask

  task automatic begin_session(input logic [23:0] cur, input string name);
    cur_time   = cur;
    man_switch = 1'b1;
    wait_clks(6);
    check({name, ".active"}, 32'(set_active), 32'd1);
    check({name, ".captured"}, 32'(set_time), 32'(cur));
  endtask

  task automatic end_session(input logic [23:0] exp, input string name);
    int l0;
    l0 = n_loads;
    man_switch = 1'b0;
    wait_clks(8);
    exp_loads++;
    check({name, ".load_count"}, 32'(n_loads - l0), 32'd1);
    check({name, ".load_value"}, 32'(last_load), 32'(exp));
    check({name, ".inactive"}, 32'(set_active), 32'd0);
  endtask

  initial begin
    vecs[0] = '{24'h123456, 3'b000, 24'h123456, "noedit"};
    vecs[1] = '{24'h235959, 3'b100, 24'h005959, "hr_23"};
    vecs[2] = '{24'h090000, 3'b100, 24'h100000, "hr_09"};
    vecs[3] = '{24'h190909, 3'b111, 24'h201010, "all_19"};
    vecs[4] = '{24'h000000, 3'b111, 24'h010101, "all_00"};
    vecs[5] = '{24'h125959, 3'b001, 24'h125900, "sec_59"};
    vecs[6] = '{24'h125959, 3'b010, 24'h120059, "min_59"};
    vecs[7] = '{24'h124839, 3'b011, 24'h124940, "min_sec"};

    resetn      = 1'b0;
    man_switch  = 1'b0;
    push_button = 3'b111;
    cur_time    = '0;
    wait_clks(3);
    check("reset.set_time", 32'(set_time), 32'd0);
    check("reset.set_load", 32'(set_load), 32'd0);
    check("reset.set_active", 32'(set_active), 32'd0);
    resetn = 1'b1;
    wait_clks(5);

    // Table: one capture/edit/commit session per record.
    for (int v = 0; v < 8; v++) begin
      begin_session(vecs[v].cur, vecs[v].name);
      if (vecs[v].mask == 3'b000) wait_clks(44);
      else                        press(vecs[v].mask, 24);
      end_session(vecs[v].exp, vecs[v].name);
      wait_clks(4);
    end

    // Repeated hour presses across the 23 -> 00 wrap.
    begin_session(24'h235959, "hrseq");
    press(3'b100, 24);
    check("hrseq.first", 32'(set_time), 32'h005959);
    press(3'b100, 24);
    check("hrseq.second", 32'(set_time), 32'h015959);
    end_session(24'h015959, "hrseq");

    // Bouncing seconds button: exactly one increment, no carry into minutes.
    begin_session(24'h123459, "bounce");
    drive_and_watch(3'b001, 60, 24, 60);
    check("bounce.changes", 32'(nchg), 32'd1);
    check("bounce.value", 32'(chg_val[0]), 32'h123400);
    end_session(24'h123400, "bounce");

    // Auto-repeat on minutes: press, +8 ticks, then every 4 ticks (tick = 4 clocks).
    begin_session(24'h125834, "repeat");
    drive_and_watch(3'b010, 0, 72, 80);
    check("repeat.changes", 32'(nchg), 32'd4);
    check("repeat.v0", 32'(chg_val[0]), 32'h125934);
    check("repeat.v1", 32'(chg_val[1]), 32'h120034);
    check("repeat.v2", 32'(chg_val[2]), 32'h120134);
    check("repeat.v3", 32'(chg_val[3]), 32'h120234);
    check("repeat.hold_gap", 32'((chg_at[1] - chg_at[0] >= 28) && (chg_at[1] - chg_at[0] <= 32)), 32'd1);
    check("repeat.gap2", 32'(chg_at[2] - chg_at[1]), 32'd16);
    check("repeat.gap3", 32'(chg_at[3] - chg_at[2]), 32'd16);
    end_session(24'h120234, "repeat");

    // All three buttons together: every field moves on the same clock.
    begin_session(24'h000000, "simul");
    drive_and_watch(3'b111, 0, 24, 60);
    check("simul.changes", 32'(nchg), 32'd1);
    check("simul.value", 32'(chg_val[0]), 32'h010101);
    end_session(24'h010101, "simul");

    // Reset mid-EDIT with the switch still on, then presses while idle.
    begin_session(24'h123456, "rst");
    press(3'b001, 24);
    check("rst.edited", 32'(set_time), 32'h123457);
    resetn = 1'b0;
    wait_clks(2);
    check("rst.set_time", 32'(set_time), 32'd0);
    check("rst.set_active", 32'(set_active), 32'd0);
    check("rst.set_load", 32'(set_load), 32'd0);
    resetn = 1'b1;
    wait_clks(40);
    check("rst.held_switch_idle", 32'(set_active), 32'd0);
    press(3'b111, 24);
    check("idle.press_time", 32'(set_time), 32'd0);
    check("idle.press_active", 32'(set_active), 32'd0);
    man_switch = 1'b0;
    wait_clks(10);
    check("idle.total_loads", 32'(n_loads), 32'(exp_loads));

    // Cycling the switch after reset re-arms set mode.
    begin_session(24'h214307, "rearm");
    end_session(24'h214307, "rearm");
    check("final.total_loads", 32'(n_loads), 32'(exp_loads));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
